// File: rtl/regf_wb_queue.sv
// Write-back queue between the execute/load result producers and the paired
// write ports of the 4R/2W register file. Accepts up to two results per cycle,
// drains up to two per cycle under a shared write enable, and offers a bypass
// lookup over the entries that are queued but not yet written.
module regf_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  // producer A is the older of the pair, producer B the younger
  input  logic                     i_valid_a,
  input  logic [AW-1:0]            i_addr_a,
  input  logic [DW-1:0]            i_data_a,
  input  logic                     i_valid_b,
  input  logic [AW-1:0]            i_addr_b,
  input  logic [DW-1:0]            i_data_b,
  output logic                     o_ready,
  // register file write side
  input  logic                     i_drain_en,
  output logic                     o_wen,
  output logic [AW-1:0]            o_wr_addr_a,
  output logic [DW-1:0]            o_wr_data_a,
  output logic [AW-1:0]            o_wr_addr_b,
  output logic [DW-1:0]            o_wr_data_b,
  // bypass lookup
  input  logic [AW-1:0]            i_lkp_addr,
  output logic                     o_lkp_hit,
  output logic [DW-1:0]            o_lkp_data,
  // status
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [CW-1:0] CntTwo   = CW'(2);

  // Entry storage is deliberately not reset; occupancy is tracked by r_count.
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_ready;
  logic          w_push_a;
  logic          w_push_b;
  logic [CW-1:0] w_push_cnt;
  logic [PW-1:0] w_wr_ptr_b;

  logic          w_wen;
  logic [PW-1:0] w_head;
  logic [PW-1:0] w_head1;
  logic          w_cnt_one;
  logic          w_addr_same;
  logic [PW-1:0] w_sel_a;
  logic [PW-1:0] w_sel_b;
  logic [CW-1:0] w_pop_cnt;

  logic [CW-1:0] w_count_d;
  logic [PW-1:0] w_rd_ptr_d;
  logic [PW-1:0] w_wr_ptr_d;

  logic          w_lkp_hit;
  logic [DW-1:0] w_lkp_data;

  // ---------------------------------------------------------------------------
  // Push side
  // ---------------------------------------------------------------------------

  // Readiness uses only the registered count; a same-cycle drain gives no credit.
  assign w_empty = (r_count == '0);
  assign w_ready = ((DepthCnt - r_count) >= CntTwo);

  assign w_push_a   = w_ready & i_valid_a;
  assign w_push_b   = w_ready & i_valid_b;
  assign w_push_cnt = CW'(w_push_a) + CW'(w_push_b);

  // B lands right after A when both push, otherwise it takes A's slot.
  assign w_wr_ptr_b = r_wr_ptr + PW'(w_push_a);

  // Write accepted results into the circular buffer in program order.
  always_ff @(posedge i_clk) begin
    if (w_push_a) begin
      r_addr[r_wr_ptr] <= i_addr_a;
      r_data[r_wr_ptr] <= i_data_a;
    end
    if (w_push_b) begin
      r_addr[w_wr_ptr_b] <= i_addr_b;
      r_data[w_wr_ptr_b] <= i_data_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain side
  // ---------------------------------------------------------------------------

  assign w_wen       = i_drain_en & ~w_empty;
  assign w_head      = r_rd_ptr;
  assign w_head1     = r_rd_ptr + PW'(1);
  assign w_cnt_one   = (r_count == CntOne);
  assign w_addr_same = (r_addr[w_head] == r_addr[w_head1]);

  // Choose which entries feed the two write ports and how many are popped.
  // With a single entry both ports carry it; with an address collision the
  // younger entry wins on both ports so the RF never sees conflicting writes.
  always_comb begin
    w_sel_a   = w_head;
    w_sel_b   = w_head1;
    w_pop_cnt = '0;
    if (w_cnt_one) begin
      w_sel_b = w_head;
    end else if (w_addr_same) begin
      w_sel_a = w_head1;
    end
    if (w_wen) begin
      w_pop_cnt = w_cnt_one ? CntOne : CntTwo;
    end
  end

  assign o_wen       = w_wen;
  assign o_wr_addr_a = r_addr[w_sel_a];
  assign o_wr_data_a = r_data[w_sel_a];
  assign o_wr_addr_b = r_addr[w_sel_b];
  assign o_wr_data_b = r_data[w_sel_b];

  // ---------------------------------------------------------------------------
  // Occupancy and pointers
  // ---------------------------------------------------------------------------

  // Next-state for count and pointers; pointers wrap naturally at DEPTH.
  always_comb begin
    w_count_d  = r_count + w_push_cnt - w_pop_cnt;
    w_wr_ptr_d = r_wr_ptr + PW'(w_push_cnt);
    w_rd_ptr_d = r_rd_ptr + PW'(w_pop_cnt);
  end

  // Pointer and count state; an asynchronous reset discards all queued entries.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_d;
      r_wr_ptr <= w_wr_ptr_d;
      r_count  <= w_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bypass lookup
  // ---------------------------------------------------------------------------

  // Scan occupied entries oldest to youngest so the youngest match is kept.
  // Entries being popped this cycle remain visible until the edge.
  always_comb begin
    w_lkp_hit  = 1'b0;
    w_lkp_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_addr[r_rd_ptr + PW'(i)] == i_lkp_addr)) begin
        w_lkp_hit  = 1'b1;
        w_lkp_data = r_data[r_rd_ptr + PW'(i)];
      end
    end
  end

  assign o_lkp_hit  = w_lkp_hit;
  assign o_lkp_data = w_lkp_data;

  assign o_ready = w_ready;
  assign o_count = r_count;
  assign o_empty = w_empty;

endmodule
